// File: rtl/arb_requester.sv
// Initiator side of the req/gnt arbitration handshake: takes a burst command, requests the bus,
// streams base+k beats while granted, then holds req low for a fixed gap. A watchdog aborts ungranted requests.
module arb_requester #(
    parameter int DATA_W     = 8,
    parameter int LEN_W      = 4,
    parameter int TIMEOUT    = 15,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              req,
    input  logic              gnt,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done,
    output logic              timeout_err
);
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, XFER = 2'd2, GAP = 2'd3} state_t;

    typedef struct packed {
        state_t            st;
        logic              req;
        logic              out_valid;
        logic [DATA_W-1:0] out_data;
        logic              out_last;
        logic              done;
        logic              terr;
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] base;
        logic [LEN_W:0]    idx;
        logic [WAIT_W-1:0] wait_cnt;
        logic [GAP_W-1:0]  gap_cnt;
    } regs_t;

    regs_t r, r_nxt;

    always_ff @(posedge clock) begin
        if (reset) r <= '0;
        else       r <= r_nxt;
    end

    always_comb begin
        r_nxt           = r;
        r_nxt.out_valid = 1'b0;
        r_nxt.out_last  = 1'b0;
        r_nxt.done      = 1'b0;
        r_nxt.terr      = 1'b0;
        case (r.st)
            IDLE: begin
                if (cmd_valid) begin
                    r_nxt.len      = cmd_len;
                    r_nxt.base     = cmd_data;
                    r_nxt.req      = 1'b1;
                    r_nxt.wait_cnt = '0;
                    r_nxt.st       = REQ;
                end
            end
            REQ: begin
                if (gnt) begin
                    r_nxt.out_valid = 1'b1;
                    r_nxt.out_data  = r.base;
                    r_nxt.out_last  = (r.len == '0);
                    r_nxt.idx       = (LEN_W + 1)'(1);
                    if (r.len == '0) begin
                        r_nxt.req     = 1'b0;
                        r_nxt.done    = 1'b1;
                        r_nxt.gap_cnt = '0;
                        r_nxt.st      = GAP;
                    end else begin
                        r_nxt.st = XFER;
                    end
                end else if (r.wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                    r_nxt.terr    = 1'b1;
                    r_nxt.req     = 1'b0;
                    r_nxt.gap_cnt = '0;
                    r_nxt.st      = GAP;
                end else begin
                    r_nxt.wait_cnt = r.wait_cnt + 1'b1;
                end
            end
            XFER: begin
                // gnt low is a pause: idx and req hold so the burst resumes at the same beat
                if (gnt) begin
                    r_nxt.out_valid = 1'b1;
                    r_nxt.out_data  = r.base + DATA_W'(r.idx);
                    r_nxt.out_last  = (r.idx == {1'b0, r.len});
                    r_nxt.idx       = r.idx + 1'b1;
                    if (r.idx == {1'b0, r.len}) begin
                        r_nxt.req     = 1'b0;
                        r_nxt.done    = 1'b1;
                        r_nxt.gap_cnt = '0;
                        r_nxt.st      = GAP;
                    end
                end
            end
            GAP: begin
                // gnt is ignored here; the arbiter's registered grant may linger after req drops
                if (r.gap_cnt == GAP_W'(GAP_CYCLES - 1)) r_nxt.st = IDLE;
                else                                     r_nxt.gap_cnt = r.gap_cnt + 1'b1;
            end
            default: r_nxt.st = IDLE;
        endcase
    end

    assign cmd_ready   = (r.st == IDLE);
    assign req         = r.req;
    assign out_valid   = r.out_valid;
    assign out_data    = r.out_data;
    assign out_last    = r.out_last;
    assign done        = r.done;
    assign timeout_err = r.terr;
endmodule

// File: tb/tb_arb_requester.sv
// Randomized scoreboard bench for arb_requester: the bench plays the arbiter (delayed, pausing,
// lagging grant) and checks beats, timeouts, gap length and reset against a queue of expected events.
module tb_arb_requester;
    localparam int DATA_W = 8, LEN_W = 4, TIMEOUT = 15, GAP_CYCLES = 2;

    logic clock = 0, reset = 1, cmd_valid = 0, gnt = 0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic cmd_ready, req, out_valid, out_last, done, timeout_err;
    logic [DATA_W-1:0] out_data;

    arb_requester #(.DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .cmd_data(cmd_data), .req(req), .gnt(gnt),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .done(done), .timeout_err(timeout_err));

    always #5 clock = ~clock;

    typedef struct {
        bit              tmo;
        logic [DATA_W-1:0] data;
        bit              last;
        int              cyc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0;
    bit   tmo_mode = 0;
    bit   run = 0;
    bit   end_v = 0;
    int   end_cyc = 0;
    logic gnt_s = 0;

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        gnt_s <= gnt;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_chk++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    // Arbiter model: grant after a short random delay, random pauses mid-burst,
    // and up to two cycles of grant lag after req falls.
    initial begin
        int gw, gd, tail;
        bit granted, prev_req;
        gw = 0; gd = 2; tail = 0; granted = 0; prev_req = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                gnt = 0; gw = 0; granted = 0; tail = 0; prev_req = 0;
            end else if (req) begin
                if (tmo_mode)           gnt = 0;
                else if (gw < gd)       begin gw++; gnt = 0; end
                else if (!granted)      begin gnt = 1; granted = 1; end
                else                    gnt = ($urandom_range(0, 3) != 0);
                prev_req = 1;
            end else begin
                if (prev_req) tail = $urandom_range(0, 2);
                if (tail > 0 && gnt) tail--;
                else begin gnt = 0; tail = 0; end
                gw = 0; granted = 0; gd = $urandom_range(1, 4); prev_req = 0;
            end
        end
    end

    // Monitor: pops one expected event per out_valid / timeout_err cycle.
    initial begin
        exp_t e;
        bit prev_rdy;
        prev_rdy = 0;
        forever begin
            @(negedge clock);
            if (run && !reset) begin
                if (out_valid || timeout_err) begin
                    if (q.size() == 0) begin
                        chk("unexpected_output", {30'd0, out_valid, timeout_err}, 32'd0);
                    end else begin
                        e = q.pop_front();
                        if (e.tmo) begin
                            chk("tmo_pulse", {31'd0, timeout_err & ~out_valid}, 32'd1);
                            chk("tmo_latency", cyc - e.cyc, TIMEOUT + 1);
                            chk("tmo_req_low", {31'd0, req}, 32'd0);
                        end else begin
                            chk("beat_valid", {31'd0, out_valid & ~timeout_err}, 32'd1);
                            chk("beat_data", {24'd0, out_data}, {24'd0, e.data});
                            chk("beat_last", {31'd0, out_last}, {31'd0, e.last});
                            chk("beat_done", {31'd0, done}, {31'd0, e.last});
                            chk("beat_req", {31'd0, req}, {31'd0, ~e.last});
                            chk("beat_granted", {31'd0, gnt_s}, 32'd1);
                        end
                    end
                end
                if (done && !out_valid) chk("done_without_beat", 32'd1, 32'd0);
                if ((done && out_valid) || timeout_err) begin
                    end_v = 1; end_cyc = cyc;
                end
                if (cmd_ready && !prev_rdy && end_v) begin
                    chk("gap_len", cyc - end_cyc, GAP_CYCLES);
                    end_v = 0;
                end
                if (cmd_ready && req) chk("req_in_idle", 32'd1, 32'd0);
                prev_rdy = cmd_ready;
            end
        end
    end

    // cmd_valid is raised before the DUT is ready so a busy DUT sees a held command
    task automatic send_cmd(input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] data, input bit tmo);
        int n;
        exp_t e;
        n = 0;
        @(negedge clock);
        cmd_len = len; cmd_data = data; cmd_valid = 1;
        while (!cmd_ready && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) begin
            chk("cmd_accept_wait", 32'd0, 32'd1);
            cmd_valid = 0;
            return;
        end
        if (tmo) begin
            e.tmo = 1; e.data = '0; e.last = 0; e.cyc = cyc;
            q.push_back(e);
        end else begin
            for (int k = 0; k <= int'(len); k++) begin
                e.tmo = 0; e.data = data + DATA_W'(k); e.last = (k == int'(len)); e.cyc = cyc;
                q.push_back(e);
            end
        end
        tmo_mode = tmo;
        @(posedge clock);
        #1 cmd_valid = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_req"}, {31'd0, req}, 32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_data"}, {24'd0, out_data}, 32'd0);
        chk({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
        chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || !cmd_ready) && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk("drain_queue", q.size(), 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        check_idle_outputs("reset");
        run = 1;

        send_cmd(4'd0, 8'h10, 0);
        send_cmd(4'd3, 8'hFE, 0);
        send_cmd(4'd0, 8'h00, 1);
        send_cmd(4'd4, 8'h40, 0);
        send_cmd(4'd15, 8'hF8, 0);
        for (int i = 0; i < 30; i++)
            send_cmd(LEN_W'($urandom), DATA_W'($urandom), ($urandom_range(0, 7) == 0));
        drain();

        // Reset mid-burst: outputs clear on the next edge and nothing further is reported
        send_cmd(4'd4, 8'h30, 0);
        n = 0;
        @(negedge clock);
        while (!out_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("reset_test_first_beat", {31'd0, out_valid}, 32'd1);
        reset = 1;
        @(posedge clock);
        #1 reset = 0;
        q.delete();
        end_v = 0;
        @(negedge clock);
        check_idle_outputs("midburst_reset");
        repeat (6) @(negedge clock);
        chk("post_reset_silent_done", {31'd0, done | timeout_err | out_valid}, 32'd0);

        send_cmd(4'd2, 8'h77, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end
endmodule
